// File: rtl/data_ram_sync.sv
// Byte-addressed big-endian synchronous data RAM with a programmable response
// latency, alignment/range fault detection and load sign/zero extension.
module data_ram_sync #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic        ReadWrite,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [3:0]  LAST_WAIT = (LATENCY == 0) ? '0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        rst_seen;
  logic        accept, enter_resp;

  logic        rw_q, sext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, din_q;

  logic        rw_e, sext_e;
  logic [1:0]  size_e;
  logic [31:0] addr_e, din_e;

  logic [1:0]  nb_m1;
  logic [32:0] last_byte;
  logic        err;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [31:0] rdata;

  logic [7:0]  mem [DEPTH];

  // rst_seen blocks an accept on the first edge after reset release
  assign accept = (state == IDLE) && Enable && rst_seen;
  assign Busy   = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = '0;
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAST_WAIT) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the access happens on the accept edge itself, so the
  // live inputs stand in for the not-yet-captured request.
  always_comb begin
    if (state == IDLE) begin
      rw_e   = ReadWrite;
      sext_e = SignExt;
      size_e = Size;
      addr_e = Address;
      din_e  = DataIn;
    end else begin
      rw_e   = rw_q;
      sext_e = sext_q;
      size_e = size_q;
      addr_e = addr_q;
      din_e  = din_q;
    end
  end

  always_comb begin
    nb_m1 = '0;
    case (size_e)
      2'b01:   nb_m1 = 2'd1;
      2'b10:   nb_m1 = 2'd3;
      default: nb_m1 = 2'd0;
    endcase
    last_byte = {1'b0, addr_e} + {31'b0, nb_m1};
    err = (size_e == 2'b11)
       || ((size_e == 2'b01) && addr_e[0])
       || ((size_e == 2'b10) && (addr_e[1:0] != 2'b00))
       || (last_byte >= 33'(DEPTH));
  end

  assign i0 = addr_e[AW-1:0];
  assign i1 = addr_e[AW-1:0] + AW'(1);
  assign i2 = addr_e[AW-1:0] + AW'(2);
  assign i3 = addr_e[AW-1:0] + AW'(3);

  always_comb begin
    rdata = '0;
    case (size_e)
      2'b00:   rdata = {{24{sext_e & mem[i0][7]}}, mem[i0]};
      2'b01:   rdata = {{16{sext_e & mem[i0][7]}}, mem[i0], mem[i1]};
      2'b10:   rdata = {mem[i0], mem[i1], mem[i2], mem[i3]};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rst_seen <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      DataOut  <= '0;
      rw_q     <= 1'b0;
      sext_q   <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      rst_seen <= 1'b1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      Done     <= (state == RESP);
      if (accept) begin
        rw_q   <= ReadWrite;
        sext_q <= SignExt;
        size_q <= Size;
        addr_q <= Address;
        din_q  <= DataIn;
      end
      if (enter_resp) begin
        Error <= err;
        if (!rw_e) DataOut <= err ? '0 : rdata;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (enter_resp && rw_e && !err) begin
      case (size_e)
        2'b00: mem[i0] <= din_e[7:0];
        2'b01: begin
          mem[i0] <= din_e[15:8];
          mem[i1] <= din_e[7:0];
        end
        2'b10: begin
          mem[i0] <= din_e[31:24];
          mem[i1] <= din_e[23:16];
          mem[i2] <= din_e[15:8];
          mem[i3] <= din_e[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_sync.sv
// Scoreboard bench for data_ram_sync: four instances at LATENCY 1, 0, 3 and 15;
// the driver queues expected responses, a monitor checks each Done pulse.
module tb_data_ram_sync;

  typedef struct {
    int unsigned inst;
    logic [31:0] data;
    logic        err;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en[4], rw[4], sx[4];
  logic [1:0]  sz[4];
  logic [31:0] ad[4], di[4], dout[4];
  logic        busy[4], done[4], err[4];

  int unsigned lat_of[4] = '{1, 0, 3, 15};
  int unsigned done_cnt[4] = '{0, 0, 0, 0};
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned pass = 0;
  exp_t        sbq[$];
  exp_t        mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_sync #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .Clk(clk), .Reset_n(rst_n), .Enable(en[0]), .ReadWrite(rw[0]), .Size(sz[0]),
    .SignExt(sx[0]), .Address(ad[0]), .DataIn(di[0]), .DataOut(dout[0]),
    .Busy(busy[0]), .Done(done[0]), .Error(err[0]));
  data_ram_sync #(.DEPTH(256), .LATENCY(0)) u_l0 (
    .Clk(clk), .Reset_n(rst_n), .Enable(en[1]), .ReadWrite(rw[1]), .Size(sz[1]),
    .SignExt(sx[1]), .Address(ad[1]), .DataIn(di[1]), .DataOut(dout[1]),
    .Busy(busy[1]), .Done(done[1]), .Error(err[1]));
  data_ram_sync #(.DEPTH(256), .LATENCY(3)) u_l3 (
    .Clk(clk), .Reset_n(rst_n), .Enable(en[2]), .ReadWrite(rw[2]), .Size(sz[2]),
    .SignExt(sx[2]), .Address(ad[2]), .DataIn(di[2]), .DataOut(dout[2]),
    .Busy(busy[2]), .Done(done[2]), .Error(err[2]));
  data_ram_sync #(.DEPTH(256), .LATENCY(15)) u_l15 (
    .Clk(clk), .Reset_n(rst_n), .Enable(en[3]), .ReadWrite(rw[3]), .Size(sz[3]),
    .SignExt(sx[3]), .Address(ad[3]), .DataIn(di[3]), .DataOut(dout[3]),
    .Busy(busy[3]), .Done(done[3]), .Error(err[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected_done inst%0d: got Done=1 required no response", i);
        end else begin
          mon_e = sbq.pop_front();
          chk($sformatf("inst%0d_source", i), i, mon_e.inst);
          chk($sformatf("inst%0d_error", i), {31'b0, err[i]}, {31'b0, mon_e.err});
          chk($sformatf("inst%0d_dataout", i), dout[i], mon_e.data);
          chk($sformatf("inst%0d_latency", i), cyc - mon_e.acc, mon_e.lat + 1);
        end
      end
    end
  end

  task automatic issue(input int i, input bit w, input logic [1:0] s, input bit x,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input bit ee, input bit push);
    exp_t t;
    @(negedge clk);
    en[i] = 1'b1; rw[i] = w; sz[i] = s; sx[i] = x; ad[i] = a; di[i] = d;
    @(posedge clk);
    #1;
    if (push) begin
      t.inst = i; t.data = ed; t.err = ee; t.acc = cyc; t.lat = lat_of[i];
      sbq.push_back(t);
    end
    // Scramble the request lines to prove they were captured at accept
    en[i] = 1'b0; rw[i] = ~w; sz[i] = ~s; sx[i] = ~x; ad[i] = ~a; di[i] = ~d;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      total++;
      $display("FAIL response_timeout: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic op(input int i, input bit w, input logic [1:0] s, input bit x,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] ed, input bit ee);
    issue(i, w, s, x, a, d, ed, ee, 1'b1);
    drain();
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk($sformatf("%s_dataout%0d", tag, i), dout[i], 32'h0);
    chk($sformatf("%s_busy%0d", tag, i), {31'b0, busy[i]}, 32'h0);
    chk($sformatf("%s_done%0d", tag, i), {31'b0, done[i]}, 32'h0);
    chk($sformatf("%s_error%0d", tag, i), {31'b0, err[i]}, 32'h0);
  endtask

  initial begin
    int unsigned n0;
    exp_t t;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; rw[i] = 1'b0; sx[i] = 1'b0; sz[i] = 2'b00; ad[i] = '0; di[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk_zero(i, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // LATENCY=1: write/read, extension, faults, boundaries
    op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    op(0, 0, 2'b00, 0, 32'h10, 32'h0, 32'h000000DE, 0);
    op(0, 1, 2'b00, 0, 32'h21, 32'h12345680, 32'h000000DE, 0);
    op(0, 0, 2'b00, 1, 32'h21, 32'h0, 32'hFFFFFF80, 0);
    op(0, 0, 2'b00, 0, 32'h21, 32'h0, 32'h00000080, 0);
    op(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFDEAD, 0);
    op(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'h0000BEEF, 0);
    op(0, 1, 2'b10, 0, 32'h13, 32'h01020304, 32'h0000BEEF, 1);
    op(0, 1, 2'b11, 0, 32'h10, 32'h0, 32'h0000BEEF, 1);
    op(0, 1, 2'b01, 0, 32'h11, 32'h0000ABCD, 32'h0000BEEF, 1);
    op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    op(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h000000EF, 0);
    op(0, 0, 2'b10, 0, 32'hFE, 32'h0, 32'h0, 1);
    op(0, 1, 2'b10, 0, 32'hFC, 32'h55AA55AA, 32'h0, 0);
    op(0, 0, 2'b00, 0, 32'hFF, 32'h0, 32'h000000AA, 0);
    op(0, 0, 2'b01, 0, 32'hFF, 32'h0, 32'h0, 1);
    op(0, 0, 2'b10, 0, 32'hFC, 32'h0, 32'h55AA55AA, 0);
    op(0, 0, 2'b00, 0, 32'h100, 32'h0, 32'h0, 1);
    op(0, 0, 2'b10, 0, 32'h80000010, 32'h0, 32'h0, 1);
    op(0, 0, 2'b10, 0, 32'hFC, 32'h0, 32'h55AA55AA, 0);
    op(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);

    // LATENCY=0: Enable held high yields an accept every second edge
    op(1, 1, 2'b10, 0, 32'h08, 32'hCAFEF00D, 32'h0, 0);
    n0 = done_cnt[1];
    @(negedge clk);
    en[1] = 1'b1; rw[1] = 1'b0; sz[1] = 2'b10; sx[1] = 1'b0; ad[1] = 32'h08;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      t.inst = 1; t.data = 32'hCAFEF00D; t.err = 1'b0; t.acc = cyc + 2 * k; t.lat = 0;
      sbq.push_back(t);
    end
    repeat (7) @(posedge clk);
    @(negedge clk);
    en[1] = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    chk("held_enable_dones", done_cnt[1] - n0, 4);
    op(1, 0, 2'b00, 1, 32'h0B, 32'h0, 32'h0000000D, 0);
    op(1, 0, 2'b01, 1, 32'h0A, 32'h0, 32'hFFFFF00D, 0);

    // LATENCY=3: strobe during WAIT is ignored
    op(2, 1, 2'b10, 0, 32'h40, 32'hA5A5A5A5, 32'h0, 0);
    op(2, 0, 2'b10, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0);
    n0 = done_cnt[2];
    issue(2, 1, 2'b10, 0, 32'h44, 32'h11223344, 32'hA5A5A5A5, 0, 1'b1);
    @(negedge clk);
    en[2] = 1'b1; rw[2] = 1'b1; sz[2] = 2'b10; ad[2] = 32'h40; di[2] = 32'h99999999;
    @(negedge clk);
    en[2] = 1'b0;
    drain();
    repeat (8) @(posedge clk);
    chk("ignored_strobe_dones", done_cnt[2] - n0, 1);
    op(2, 0, 2'b10, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0);
    op(2, 0, 2'b10, 0, 32'h44, 32'h0, 32'h11223344, 0);

    // Reset during WAIT aborts the write
    issue(2, 1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero(2, "midreset");
    repeat (2) @(posedge clk);
    #1;
    chk_zero(2, "heldreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    op(2, 0, 2'b10, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0);

    // LATENCY=15
    op(3, 1, 2'b10, 0, 32'h00, 32'h0BADF00D, 32'h0, 0);
    op(3, 0, 2'b10, 0, 32'h00, 32'h0, 32'h0BADF00D, 0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
